// File: rtl/alu_mul_seq.sv
// Sequential 32x32 shift-add multiplier that borrows a shared external ALU for every add/negate step.
// Signed mode (operand negation and final 64-bit sign fix) is built only when ALU_MUL_SEQ_SIGNED_EN is defined.
module alu_mul_seq #(
    parameter int STEPS = 32
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Signed,
    input  logic [31:0] Rs1,
    input  logic [31:0] Rs2,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] ProdHi,
    output logic [31:0] ProdLo,
    output logic [5:0]  AluOp3,
    output logic [31:0] AluA,
    output logic [31:0] AluB,
    output logic        AluCin,
    input  logic [31:0] AluOut,
    input  logic        AluC
);
    localparam int CNT_W = $clog2(STEPS);

    localparam logic [5:0] OP_NOP   = 6'b000000;
    localparam logic [5:0] OP_ADDCC = 6'b010000;
`ifdef ALU_MUL_SEQ_SIGNED_EN
    localparam logic [5:0] OP_SUB   = 6'b000100;
    localparam logic [5:0] OP_SUBCC = 6'b010100;
    localparam logic [5:0] OP_SUBX  = 6'b001100;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_NEGA, S_NEGB, S_MUL, S_FIXLO, S_FIXHI, S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_mcand;
    logic [31:0]      r_mlr;
    logic [31:0]      r_acc;
    logic [31:0]      r_prod_hi;
    logic [31:0]      r_prod_lo;
    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

`ifdef ALU_MUL_SEQ_SIGNED_EN
    logic             r_signed;
    logic             r_neg;
    logic             r_borrow;
`else
    logic             w_unused_signed;
    assign w_unused_signed = Signed;
`endif

    assign w_last = (r_cnt == CNT_W'(STEPS - 1));

    always_comb begin
        w_next = r_state;
        AluOp3 = OP_NOP;
        AluA   = '0;
        AluB   = '0;
        AluCin = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
`ifdef ALU_MUL_SEQ_SIGNED_EN
                    w_next = Signed ? S_NEGA : S_MUL;
`else
                    w_next = S_MUL;
`endif
                end
            end
`ifdef ALU_MUL_SEQ_SIGNED_EN
            S_NEGA: begin
                AluOp3 = OP_SUB;
                AluB   = r_mcand;
                w_next = S_NEGB;
            end
            S_NEGB: begin
                AluOp3 = OP_SUB;
                AluB   = r_mlr;
                w_next = S_MUL;
            end
`endif
            S_MUL: begin
                AluOp3 = OP_ADDCC;
                AluA   = r_acc;
                AluB   = r_mlr[0] ? r_mcand : '0;
                if (w_last) begin
`ifdef ALU_MUL_SEQ_SIGNED_EN
                    w_next = (r_signed && r_neg) ? S_FIXLO : S_DONE;
`else
                    w_next = S_DONE;
`endif
                end
            end
`ifdef ALU_MUL_SEQ_SIGNED_EN
            // Two-word negate of the magnitude product: low word first, its borrow feeds the high word.
            S_FIXLO: begin
                AluOp3 = OP_SUBCC;
                AluB   = r_mlr;
                w_next = S_FIXHI;
            end
            S_FIXHI: begin
                AluOp3 = OP_SUBX;
                AluB   = r_acc;
                AluCin = r_borrow;
                w_next = S_DONE;
            end
`endif
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_mcand   <= '0;
            r_mlr     <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_prod_hi <= '0;
            r_prod_lo <= '0;
`ifdef ALU_MUL_SEQ_SIGNED_EN
            r_signed  <= 1'b0;
            r_neg     <= 1'b0;
            r_borrow  <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_mcand  <= Rs1;
                        r_mlr    <= Rs2;
                        r_acc    <= '0;
                        r_cnt    <= '0;
`ifdef ALU_MUL_SEQ_SIGNED_EN
                        r_signed <= Signed;
                        r_neg    <= Rs1[31] ^ Rs2[31];
`endif
                    end
                end
`ifdef ALU_MUL_SEQ_SIGNED_EN
                // 0x80000000 negates to itself, which read unsigned is the correct magnitude 2^31.
                S_NEGA: begin
                    if (r_mcand[31]) r_mcand <= AluOut;
                end
                S_NEGB: begin
                    if (r_mlr[31]) r_mlr <= AluOut;
                end
`endif
                S_MUL: begin
                    {r_acc, r_mlr} <= {AluC, AluOut, r_mlr[31:1]};
                    r_cnt          <= r_cnt + 1'b1;
                end
`ifdef ALU_MUL_SEQ_SIGNED_EN
                S_FIXLO: begin
                    r_mlr    <= AluOut;
                    r_borrow <= AluC;
                end
                S_FIXHI: begin
                    r_acc <= AluOut;
                end
`endif
                S_DONE: begin
                    r_prod_hi <= r_acc;
                    r_prod_lo <= r_mlr;
                end
                default: begin
                end
            endcase
        end
    end

    assign Busy   = (r_state != S_IDLE);
    assign Done   = (r_state == S_DONE);
    assign ProdHi = r_prod_hi;
    assign ProdLo = r_prod_lo;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a behavioural shared-ALU model and a result scoreboard.
// Expectations follow ALU_MUL_SEQ_SIGNED_EN the same way the design build does.
module tb_alu_mul_seq;
    logic        Clk = 1'b0;
    logic        Reset, Start, sgn;
    logic [31:0] Rs1, Rs2;
    logic        Busy, Done;
    logic [31:0] ProdHi, ProdLo;
    logic [5:0]  AluOp3;
    logic [31:0] AluA, AluB, AluOut;
    logic        AluCin, AluC;
    logic [32:0] alu_t;

    typedef struct {
        logic [63:0] prod;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [63:0] prev_prod = '0;

    alu_mul_seq #(.STEPS(32)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Signed(sgn),
        .Rs1(Rs1), .Rs2(Rs2), .Busy(Busy), .Done(Done),
        .ProdHi(ProdHi), .ProdLo(ProdLo), .AluOp3(AluOp3),
        .AluA(AluA), .AluB(AluB), .AluCin(AluCin),
        .AluOut(AluOut), .AluC(AluC)
    );

    initial forever #5 Clk = ~Clk;

    // Shared ALU: carry flag is carry-out for adds and borrow-out for subtracts.
    always_comb begin
        alu_t  = '0;
        AluOut = '0;
        AluC   = 1'b0;
        case (AluOp3)
            6'b010000: begin
                alu_t  = {1'b0, AluA} + {1'b0, AluB} + {32'd0, AluCin};
                AluOut = alu_t[31:0];
                AluC   = alu_t[32];
            end
            6'b000100: AluOut = AluA - AluB;
            6'b010100: begin
                alu_t  = {1'b0, AluA} - {1'b0, AluB};
                AluOut = alu_t[31:0];
                AluC   = alu_t[32];
            end
            6'b001100: begin
                alu_t  = {1'b0, AluA} - {1'b0, AluB} - {32'd0, AluCin};
                AluOut = alu_t[31:0];
                AluC   = alu_t[32];
            end
            default: begin
            end
        endcase
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] ea, eb;
        ea = {32'd0, a};
        eb = {32'd0, b};
`ifdef ALU_MUL_SEQ_SIGNED_EN
        if (s) begin
            ea = {{32{a[31]}}, a};
            eb = {{32{b[31]}}, b};
        end
`endif
        return ea * eb;
    endfunction

    function automatic int model_lat(input logic [31:0] a, input logic [31:0] b, input logic s);
`ifdef ALU_MUL_SEQ_SIGNED_EN
        if (s) return (a[31] ^ b[31]) ? 37 : 35;
`endif
        return 33;
    endfunction

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic s, input bit pulse_busy);
        exp_t e;
        int   n;
        e.prod = model_prod(a, b, s);
        e.lat  = model_lat(a, b, s);
        sb.push_back(e);
        Rs1 = a; Rs2 = b; sgn = s; Start = 1'b1;
        tick();
        Start = 1'b0; Rs1 = ~a; Rs2 = b ^ 32'h5A5A_5A5A; sgn = ~s;
        check("busy_after_start", 64'(Busy), 64'd1);
        check("prod_hold", {ProdHi, ProdLo}, prev_prod);
        n = 1;
        while (!Done && n < 100) begin
            Start = pulse_busy && (n == 5 || n == 10);
            tick();
            n++;
        end
        Start = 1'b0;
        if (sb.size() > 0) e = sb.pop_front();
        check("latency", 64'(n), 64'(e.lat));
        check("busy_at_done", 64'(Busy), 64'd1);
        // A request in the DONE cycle must not start a new multiply.
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("done_pulse_width", 64'(Done), 64'd0);
        check("start_in_done_ignored", 64'(Busy), 64'd0);
        check("prod_hi", 64'(ProdHi), 64'(e.prod[63:32]));
        check("prod_lo", 64'(ProdLo), 64'(e.prod[31:0]));
        check("alu_idle", {26'd0, AluOp3, AluCin, AluA | AluB}, 64'd0);
        prev_prod = e.prod;
    endtask

    initial begin
        int dones;
        Reset = 1'b1; Start = 1'b0; sgn = 1'b0; Rs1 = '0; Rs2 = '0;
        tick();
        tick();
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        check("rst_prod", {ProdHi, ProdLo}, 64'd0);
        check("rst_alu", {26'd0, AluOp3, AluCin, AluA | AluB}, 64'd0);
        Reset = 1'b0;
        tick();

        run_mul(32'd7, 32'd6, 1'b0, 1'b0);
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_mul(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0);
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_mul(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
        run_mul(32'h8000_0000, 32'd1, 1'b1, 1'b0);
        run_mul(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b0);
        run_mul(32'd0, 32'h1234_5678, 1'b1, 1'b0);
        run_mul(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0);
        run_mul(32'h0000_1234, 32'h0000_5678, 1'b0, 1'b1);

        // Reset partway through the shift-add loop.
        Rs1 = 32'd7; Rs2 = 32'd6; sgn = 1'b0; Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 1; i < 12; i++) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("midrst_busy", 64'(Busy), 64'd0);
        check("midrst_done", 64'(Done), 64'd0);
        check("midrst_prod", {ProdHi, ProdLo}, 64'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (Done) dones++;
        end
        check("midrst_no_done", 64'(dones), 64'd0);
        prev_prod = '0;

        // Reset wins over a same-cycle Start.
        Reset = 1'b1; Start = 1'b1; Rs1 = 32'd3; Rs2 = 32'd3;
        tick();
        Reset = 1'b0; Start = 1'b0;
        check("rst_vs_start", 64'(Busy), 64'd0);
        tick();
        check("rst_vs_start_idle", 64'(Busy), 64'd0);

        for (int i = 0; i < 4; i++)
            run_mul($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 SHALL have parameter STEPS, default 32, meaning the number of shift-add iterations per multiply (fixed at 32 for 32-bit operands).
REQ-002 SHALL have port Clk  input  1  rising-edge clock; the only clock.
REQ-003 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port Start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port Signed  input  1  1 = two's-complement multiply, 0 = unsigned; sampled with Start.
REQ-006 SHALL have port Rs1  input  32  multiplicand; sampled with Start.
REQ-007 SHALL have port Rs2  input  32  multiplier; sampled with Start.
REQ-008 SHALL have port Busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port Done  output  1  one-cycle pulse, asserted in the DONE state.
REQ-010 SHALL have port ProdHi  output  32  product bits 63:32, registered.
REQ-011 SHALL have port ProdLo  output  32  product bits 31:0, registered.
REQ-012 SHALL have port AluOp3  output  6  Op3 driven to the shared ALU.
REQ-013 SHALL have ports AluA, AluB  output  32 each  ALU Ain/Bin operands.
REQ-014 SHALL have port AluCin  output  1  ALU carry-in.
REQ-015 SHALL have ports AluOut  input  32 and AluC  input  1  ALU result and carry flag, combinational, same cycle.

Function
REQ-016 SHALL implement states IDLE, NEGA, NEGB, MUL, FIXLO, FIXHI, DONE.
REQ-017 IDLE: Start=1 SHALL latch Rs1 into mcand, Rs2 into mlr, clear acc, clear 5-bit step counter, record Signed and sign flag (Rs1[31]^Rs2[31]); next state NEGA if Signed else MUL.
REQ-018 NEGA: SHALL drive AluOp3=000100 (SUB), AluA=0, AluB=mcand; mcand SHALL load AluOut only if mcand[31]=1; next NEGB.
REQ-019 NEGB: same as NEGA applied to mlr; next MUL.
REQ-020 MUL: SHALL drive AluOp3=010000 (ADDcc), AluA=acc, AluB = mlr[0] ? mcand : 0, AluCin=0; SHALL load {acc,mlr} <= {AluC,AluOut,mlr} >> 1; counter increments.
REQ-021 MUL SHALL exit after exactly STEPS cycles (counter 31 -> wraps to 0); next FIXLO if signed and sign flag set, else DONE.
REQ-022 FIXLO: SHALL drive SUBcc (010100), AluA=0, AluB=mlr; mlr<=AluOut; borrow register<=AluC.
REQ-023 FIXHI: SHALL drive SUBX (001100), AluA=0, AluB=acc, AluCin=borrow; acc<=AluOut; next DONE.
REQ-024 DONE: SHALL load ProdHi<=acc, ProdLo<=mlr, pulse Done; next IDLE.
REQ-025 Latency Start-to-Done: unsigned 33 cycles; signed without sign fix 35; signed with sign fix 37.
REQ-026 Start while Busy SHALL be ignored; Start in the DONE cycle SHALL be ignored.
REQ-027 In IDLE and DONE SHALL drive AluOp3=000000, AluA=0, AluB=0, AluCin=0.
REQ-028 ProdHi/ProdLo SHALL hold the last result until the next DONE.
REQ-029 Operand 0x80000000 in signed mode SHALL be treated as magnitude 2^31 (negation result used unsigned).

Reset
REQ-030 Reset=1 at a rising edge SHALL force IDLE, Busy=0, Done=0, ProdHi=ProdLo=0, acc/mlr/mcand/counter/borrow=0, regardless of state.
REQ-031 Reset SHALL take priority over Start in the same cycle; no partial result SHALL reach ProdHi/ProdLo.

Configuration
REQ-032 With macro ALU_MUL_SEQ_SIGNED_EN defined, SHALL implement signed mode as above.
REQ-033 Without ALU_MUL_SEQ_SIGNED_EN, Signed SHALL be ignored, NEGA/NEGB/FIXLO/FIXHI SHALL be absent, and all multiplies SHALL be unsigned with 33-cycle latency.

Verification
REQ-034 Unsigned Rs1=7, Rs2=6 -> Done at cycle 33, ProdHi=0x00000000, ProdLo=0x0000002A.
REQ-035 Unsigned Rs1=Rs2=0xFFFFFFFF -> ProdHi=0xFFFFFFFE, ProdLo=0x00000001.
REQ-036 Signed Rs1=0xFFFFFFFD (-3), Rs2=5 -> Done at cycle 37, ProdHi=0xFFFFFFFF, ProdLo=0xFFFFFFF1.
REQ-037 Signed Rs1=Rs2=0xFFFFFFFF -> Done at cycle 35, ProdHi=0, ProdLo=1.
REQ-038 Start pulses at cycles 5 and 10 of a busy multiply -> ignored, single Done, result of first request only.
REQ-039 Reset asserted in MUL cycle 12 -> next cycle IDLE, Busy=0, ProdHi=ProdLo=0, no Done pulse.
